// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer controller: moves one register onto another, or loads an
// immediate, using one-hot read/write strobes in a fixed four-state handshake.
module bus_xfer_ctrl #(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [2:0]      src,
  input  logic [2:0]      dst,
  input  logic            imm,
  input  logic [DW-1:0]   imm_data,
  output logic [NREG-1:0] re,
  output logic [NREG-1:0] we,
  inout  wire  [DW-1:0]   data_bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [7:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [2:0]      src_q, src_n;
  logic [2:0]      dst_q, dst_n;
  logic            imm_q, imm_n;
  logic [DW-1:0]   data_q, data_n;

  logic [NREG-1:0] re_n, we_n;
  logic            bus_oe, bus_oe_n;
  logic            busy_n, done_n, err_n;
  logic [7:0]      cnt_n;
  logic            req_ok;

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i] = (idx == 3'(i));
    return v;
  endfunction

  // A move needs a distinct, existing source; an immediate ignores src entirely.
  assign req_ok = (int'(dst) < NREG) &&
                  (imm || ((int'(src) < NREG) && (src != dst)));

  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // through the case statements can leave a value held, which would infer a latch.
    state_n  = state;
    src_n    = src_q;
    dst_n    = dst_q;
    imm_n    = imm_q;
    data_n   = data_q;
    cnt_n    = xfer_cnt;
    re_n     = '0;
    we_n     = '0;
    bus_oe_n = 1'b0;
    busy_n   = 1'b1;
    done_n   = 1'b0;
    err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (req) begin
          src_n   = src;
          dst_n   = dst;
          imm_n   = imm;
          data_n  = imm_data;
          state_n = req_ok ? SETUP : DONE;
        end
      end
      SETUP: state_n = XFER;
      XFER: begin
        state_n = DONE;
        cnt_n   = xfer_cnt + 8'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register cleanly.
    unique case (state_n)
      IDLE: busy_n = 1'b0;
      SETUP: begin
        re_n     = imm_n ? '0 : onehot(src_n);
        bus_oe_n = imm_n;
      end
      XFER: begin
        re_n     = imm_n ? '0 : onehot(src_n);
        bus_oe_n = imm_n;
        we_n     = onehot(dst_n);
      end
      DONE: begin
        done_n = 1'b1;
        // Only a rejected request reaches DONE straight from IDLE.
        err_n  = (state == IDLE);
      end
      default: busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_q    <= 1'b0;
      data_q   <= '0;
      re       <= '0;
      we       <= '0;
      bus_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_n;
      src_q    <= src_n;
      dst_q    <= dst_n;
      imm_q    <= imm_n;
      data_q   <= data_n;
      re       <= re_n;
      we       <= we_n;
      bus_oe   <= bus_oe_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      xfer_cnt <= cnt_n;
    end
  end

  assign data_bus = bus_oe ? data_q : {DW{1'bz}};

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: a register-file model on the shared bus,
// a vector table of transfers, and directed reset / busy / wrap sequences.
module tb_bus_xfer_ctrl;
  localparam int NREG = 6;
  localparam int DW   = 8;

  logic            clk = 1'b0;
  logic            rst, req, imm;
  logic [2:0]      src, dst;
  logic [DW-1:0]   imm_data;
  logic [NREG-1:0] re, we;
  wire  [DW-1:0]   data_bus;
  logic            busy, done, err;
  logic [7:0]      xfer_cnt;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.NREG(NREG), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .src(src), .dst(dst), .imm(imm),
    .imm_data(imm_data), .re(re), .we(we), .data_bus(data_bus),
    .busy(busy), .done(done), .err(err), .xfer_cnt(xfer_cnt)
  );

  // Register file sitting on the bus: drives it on re, captures it on we.
  logic [DW-1:0] regs [NREG];
  logic          env_clr;
  logic          env_oe;
  logic [DW-1:0] env_val;

  always_comb begin
    env_oe  = |re;
    env_val = '0;
    for (int i = 0; i < NREG; i++) if (re[i]) env_val = regs[i];
  end

  assign data_bus = env_oe ? env_val : {DW{1'bz}};

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h10 + 8'(i);
    end else begin
      for (int i = 0; i < NREG; i++) if (we[i]) regs[i] <= data_bus;
    end
  end

  typedef struct packed {
    logic       imm;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] data;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t          sb [$];
  vec_t          vecs [10];
  logic [DW-1:0] exp_regs [NREG];
  logic [7:0]    cnt_model;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [NREG-1:0] oh(input int i);
    logic [NREG-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and run the every-cycle checks.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    check("re_onehot0", 32'($onehot0(re)), 1);
    check("we_onehot0", 32'($onehot0(we)), 1);
    check("re_vs_drive", 32'((re != '0) && dut.bus_oe), 0);
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb.pop_front();
        check("done_err", err, e.err);
        check("done_cnt", xfer_cnt, e.cnt);
      end
    end else begin
      check("err_without_done", err, 0);
    end
  endtask

  // Caller is just past a falling edge with the DUT idle.
  task automatic run_xfer(input vec_t v);
    exp_t          e;
    logic [DW-1:0] expval;
    req      = 1'b1;
    imm      = v.imm;
    src      = v.src;
    dst      = v.dst;
    imm_data = v.data;
    expval   = v.imm ? v.data : ((!v.err) ? exp_regs[v.src] : '0);
    if (!v.err) cnt_model = cnt_model + 8'd1;
    e.err = v.err;
    e.cnt = cnt_model;
    sb.push_back(e);
    tick();
    req      = 1'b0;
    imm      = 1'($urandom);
    src      = 3'($urandom);
    dst      = 3'($urandom);
    imm_data = 8'($urandom);
    if (!v.err) begin
      check("setup_busy", busy, 1);
      check("setup_re", re, v.imm ? '0 : oh(int'(v.src)));
      check("setup_we", we, 0);
      check("setup_drive", dut.bus_oe, v.imm);
      if (v.imm) check("setup_bus", data_bus, v.data);
      tick();
      check("xfer_re", re, v.imm ? '0 : oh(int'(v.src)));
      check("xfer_we", we, oh(int'(v.dst)));
      check("xfer_drive", dut.bus_oe, v.imm);
      check("xfer_bus", data_bus, expval);
      tick();
      check("done_pulse", done, 1);
      check("done_strobes", {re, we}, 0);
      check("done_drive", dut.bus_oe, 0);
      check("done_busy", busy, 1);
      tick();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      exp_regs[v.dst] = expval;
      check("reg_dst", regs[v.dst], expval);
    end else begin
      check("rej_done", done, 1);
      check("rej_busy", busy, 1);
      check("rej_strobes", {re, we}, 0);
      check("rej_drive", dut.bus_oe, 0);
      tick();
      check("rej_idle_busy", busy, 0);
      check("rej_idle_done", done, 0);
    end
  endtask

  initial begin
    vecs[0] = '{imm: 1'b1, src: 3'd0, dst: 3'd2, data: 8'hA5, err: 1'b0};
    vecs[1] = '{imm: 1'b0, src: 3'd2, dst: 3'd5, data: 8'h00, err: 1'b0};
    vecs[2] = '{imm: 1'b0, src: 3'd3, dst: 3'd3, data: 8'h00, err: 1'b1};
    vecs[3] = '{imm: 1'b1, src: 3'd0, dst: 3'd6, data: 8'h11, err: 1'b1};
    vecs[4] = '{imm: 1'b0, src: 3'd7, dst: 3'd1, data: 8'h00, err: 1'b1};
    vecs[5] = '{imm: 1'b1, src: 3'd3, dst: 3'd3, data: 8'hC3, err: 1'b0};
    vecs[6] = '{imm: 1'b0, src: 3'd5, dst: 3'd0, data: 8'h00, err: 1'b0};
    vecs[7] = '{imm: 1'b1, src: 3'd1, dst: 3'd5, data: 8'h00, err: 1'b0};
    vecs[8] = '{imm: 1'b1, src: 3'd6, dst: 3'd0, data: 8'hFF, err: 1'b0};
    vecs[9] = '{imm: 1'b0, src: 3'd0, dst: 3'd4, data: 8'h00, err: 1'b0};
    for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h10 + 8'(i);
    cnt_model = 8'd0;

    rst = 1'b1; env_clr = 1'b1; req = 1'b0; imm = 1'b0;
    src = '0; dst = '0; imm_data = '0;
    @(posedge clk);
    tick();
    check("rst_re", re, 0);
    check("rst_we", we, 0);
    check("rst_drive", dut.bus_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", xfer_cnt, 0);
    rst = 1'b0; env_clr = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_xfer(vecs[i]);
    check("vec_cnt", xfer_cnt, cnt_model);

    // Reset during XFER aborts: no done, counter cleared.
    req = 1'b1; imm = 1'b1; dst = 3'd1; imm_data = 8'h3C;
    tick();
    req = 1'b0;
    tick();
    check("abort_xfer_we", we, oh(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_model = 8'd0;
    // The we strobe already high in XFER is sampled by the register at the reset edge.
    exp_regs[1] = 8'h3C;
    check("abort_strobes", {re, we}, 0);
    check("abort_drive", dut.bus_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cnt", xfer_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_we", we, 0);
    end

    // Reset during SETUP, with req held high across the reset edge.
    req = 1'b1; imm = 1'b1; dst = 3'd2; imm_data = 8'h99;
    tick();
    check("setup_rst_pre", dut.bus_oe, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    check("setup_rst_busy", busy, 0);
    check("setup_rst_drive", dut.bus_oe, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("setup_rst_no_we", we, 0);
    end
    check("setup_rst_reg", regs[2], exp_regs[2]);

    // Requests during SETUP and DONE are dropped, not queued.
    begin
      exp_t e;
      req = 1'b1; imm = 1'b1; dst = 3'd3; imm_data = 8'h5A;
      cnt_model = cnt_model + 8'd1;
      e.err = 1'b0;
      e.cnt = cnt_model;
      sb.push_back(e);
    end
    tick();
    req = 1'b1; dst = 3'd4; imm_data = 8'h77;
    tick();
    req = 1'b0;
    check("busy_ign_we", we, oh(3));
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    check("busy_ign_idle", busy, 0);
    exp_regs[3] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_ign_no_start", busy, 0);
    end
    check("busy_ign_reg3", regs[3], exp_regs[3]);
    check("busy_ign_reg4", regs[4], exp_regs[4]);

    // Back-to-back with req held: 256 transfers wrap the counter to zero.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_model = 8'd0;
    check("wrap_start_cnt", xfer_cnt, 0);
    req = 1'b1; imm = 1'b1; dst = 3'd4; imm_data = 8'h5A;
    for (int k = 0; k < 256; k++) begin
      exp_t e;
      cnt_model = cnt_model + 8'd1;
      e.err = 1'b0;
      e.cnt = cnt_model;
      sb.push_back(e);
    end
    for (int j = 0; j < 1024; j++) begin
      check("b2b_busy", busy, (j % 4 == 0) ? 0 : 1);
      tick();
    end
    req = 1'b0;
    check("wrap_cnt", xfer_cnt, 32'(cnt_model));
    check("wrap_zero", xfer_cnt, 0);
    exp_regs[4] = 8'h5A;
    tick();
    tick();
    check("b2b_reg4", regs[4], exp_regs[4]);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 8: number of registers on the shared bus (2..8).
REQ-002 SHALL have parameter DW, default 8: data bus width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 1: transfer request, sampled only in IDLE.
REQ-006 SHALL have port src, input, 3: source register index, read-transfer only.
REQ-007 SHALL have port dst, input, 3: destination register index.
REQ-008 SHALL have port imm, input, 1: 1 = load imm_data into dst; 0 = register-to-register move.
REQ-009 SHALL have port imm_data, input, DW: immediate value.
REQ-010 SHALL have port re, output, NREG: one-hot read enables, one bit per register.
REQ-011 SHALL have port we, output, NREG: one-hot write enables, one bit per register.
REQ-012 SHALL have port data_bus, inout, DW: shared bus, driven only during an immediate transfer, else high-Z.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1: qualifies done; high = request rejected.
REQ-016 SHALL have port xfer_cnt, output, 8: count of successful transfers.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, XFER, DONE, all outputs registered.
REQ-018 IDLE with req=1 at edge N SHALL latch src, dst, imm and imm_data.
REQ-019 After REQ-018, a valid request SHALL enter SETUP at edge N; an invalid one SHALL go to DONE with err=1.
REQ-020 Invalid request: dst>=NREG; or imm=0 and (src>=NREG or src==dst).
REQ-021 SETUP, imm=0: exactly re[src]=1, all we=0, for one cycle, letting the bus settle.
REQ-022 SETUP, imm=1: all re=0, data_bus driven with latched imm_data, all we=0.
REQ-023 XFER SHALL keep the SETUP bus source active and also assert we[dst]=1 for exactly one cycle.
REQ-024 Valid-request timeline: SETUP cycle N+1, XFER N+2, DONE N+3, IDLE N+4; busy high N+1..N+3.
REQ-025 DONE SHALL assert done=1 for one cycle with all re/we=0 and data_bus high-Z; err is valid only while done=1, else 0.
REQ-026 xfer_cnt SHALL increment by 1 on XFER->DONE, wrapping 255->0; rejected requests SHALL not change it.
REQ-027 req while busy=1, including the DONE cycle, SHALL be ignored, not queued; changes to src/dst/imm/imm_data after capture SHALL have no effect.
REQ-028 At most one re bit and one we bit SHALL be high in any cycle; re and data_bus drive SHALL never overlap.
REQ-029 back-to-back: req held high SHALL start a new transfer every 4 cycles (accepted in each IDLE cycle).

Reset
REQ-030 rst=1 at an edge SHALL force IDLE and re=0, we=0, data_bus high-Z, busy=0, done=0, err=0, xfer_cnt=0, from any state.
REQ-031 rst asserted in SETUP or XFER SHALL abort the transfer with no further we pulse and no done pulse.
REQ-032 rst SHALL take priority over req in the same cycle.

Verification
REQ-033 Immediate load: imm=1, dst=2, imm_data=8'hA5, req for 1 cycle -> data_bus=A5 for 2 cycles, we[2] high only in cycle 2, done=1/err=0 in cycle 3, xfer_cnt=1.
REQ-034 Move: src=2, dst=5 after REQ-033 -> re[2] for 2 cycles, we[5] in the second, register 5 then holds A5, xfer_cnt=2.
REQ-035 Reject: imm=0, src=dst=3 -> done=1 and err=1 in the cycle after capture, no re/we activity, xfer_cnt unchanged.
REQ-036 Reset mid-transfer: rst during XFER of an immediate 8'h3C to dst=1 -> next cycle all strobes 0, bus Z, busy=0, no done, xfer_cnt=0.
REQ-037 Busy-ignore and wrap: req toggled during SETUP is not accepted; 256 continuous valid transfers return xfer_cnt to 0.
REQ-038 Bench: every cycle checks re and we each one-hot-or-zero, and that re and data_bus drive are never active together.
